// File: rtl/mb_sequencer_if.sv
// Command, response and Math Box bus bundle for mb_sequencer.
// master = host CPU / Math Box side, slave = the sequencer itself.
interface mb_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_read;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_timeout;

  logic [7:0]  mb_eab;
  logic [7:0]  mb_edb_in;
  logic        mb_start;
  logic        mb_ylo;
  logic        mb_yhi;
  logic [7:0]  mb_edb_out;
  logic        mb_stop;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_read, rsp_ready, mb_edb_out, mb_stop,
    input  cmd_ready, rsp_valid, rsp_result, rsp_timeout,
    input  mb_eab, mb_edb_in, mb_start, mb_ylo, mb_yhi
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_read, rsp_ready, mb_edb_out, mb_stop,
    output cmd_ready, rsp_valid, rsp_result, rsp_timeout,
    output mb_eab, mb_edb_in, mb_start, mb_ylo, mb_yhi
  );
endinterface

// File: rtl/mb_sequencer.sv
// Runs one Math Box operation per host command: load, start, wait for STOP (with timeout),
// optionally read the 16-bit result through YLO/YHI, then hand back a response.
module mb_sequencer #(
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic          clk_6MHz,
  input  logic          reset_n,
  mb_sequencer_if.slave bus,
  output logic          busy
);

  localparam logic [9:0] WrLast     = 10'(WR_CYCLES - 1);
  localparam logic [9:0] RdLast     = 10'(RD_CYCLES - 1);
  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StStart,
    StArm,
    StRun,
    StReadLo,
    StGap,
    StReadHi,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  cnt_inc;
  logic [7:0]  addr_q, data_q, lo_q;
  logic        read_q;
  logic [15:0] result_q;
  logic        timeout_q;

  logic accept, run_done, run_expire, lo_last, hi_last;

  assign cnt_inc    = cnt_q + 10'd1;
  assign accept     = (state_q == StIdle) && bus.cmd_valid;
  assign run_done   = (state_q == StRun) && bus.mb_stop;
  // STOP on the expiry clock wins: run_expire only fires with STOP still low.
  assign run_expire = (state_q == StRun) && !bus.mb_stop && (cnt_inc == TimeoutCnt);
  assign lo_last    = (state_q == StReadLo) && (cnt_q == RdLast);
  assign hi_last    = (state_q == StReadHi) && (cnt_q == RdLast);

  always_ff @(posedge clk_6MHz) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (cnt_q == WrLast) begin
          state_d = StStart;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StStart: state_d = StArm;
      StArm: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (run_done) begin
          state_d = read_q ? StReadLo : StResp;
          cnt_d   = '0;
        end else if (run_expire) begin
          state_d = StResp;
        end
      end
      StReadLo: begin
        if (lo_last) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGap: state_d = StReadHi;
      StReadHi: begin
        if (hi_last) begin
          state_d = StResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Result only changes on the way into RESP so the previous response stays visible meanwhile.
  always_ff @(posedge clk_6MHz) begin
    if (!reset_n) begin
      addr_q    <= '0;
      data_q    <= '0;
      read_q    <= 1'b0;
      lo_q      <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
        read_q <= bus.cmd_read;
      end
      if (run_done && !read_q) begin
        result_q  <= 16'h0000;
        timeout_q <= 1'b0;
      end
      if (run_expire) begin
        result_q  <= 16'hFFFF;
        timeout_q <= 1'b1;
      end
      if (lo_last) lo_q <= bus.mb_edb_out;
      if (hi_last) begin
        result_q  <= {bus.mb_edb_out, lo_q};
        timeout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.cmd_ready   = (state_q == StIdle);
    busy            = (state_q != StIdle);
    bus.mb_start    = (state_q == StStart);
    bus.mb_ylo      = (state_q == StReadLo);
    bus.mb_yhi      = (state_q == StReadHi);
    bus.rsp_valid   = (state_q == StResp);
    bus.rsp_result  = result_q;
    bus.rsp_timeout = timeout_q;
    bus.mb_eab      = busy ? addr_q : 8'h00;
    bus.mb_edb_in   = busy ? data_q : 8'h00;
  end

endmodule

// File: tb/tb_mb_sequencer.sv
// Scoreboard bench for mb_sequencer with a reactive Math Box model and a strobe monitor.
module tb_mb_sequencer;
  localparam int WR = 2;
  localparam int RD = 2;
  localparam int TO = 1023;
  localparam int NCMD = 7;
  localparam int WAIT_MAX = 3000;

  logic clk_6MHz = 1'b0;
  logic reset_n  = 1'b0;
  logic busy;

  mb_sequencer_if bus();

  mb_sequencer #(
    .WR_CYCLES(WR),
    .RD_CYCLES(RD),
    .TIMEOUT  (TO)
  ) dut (
    .clk_6MHz(clk_6MHz),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy    (busy)
  );

  always #5 clk_6MHz = ~clk_6MHz;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
    int         stop_n;  // RUN clocks with STOP low before it rises; -1 = never
    logic [7:0] lo;
    logic [7:0] hi;
    int         hold;    // clocks of rsp_ready=0 before accepting the response
  } cmd_t;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] result;
    logic        to;
    logic        rd;
    int          lat;
    int          hold;
    int          acc;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   hs_cyc  = 0;
  bit   abort   = 0;
  exp_t sb[$];
  cmd_t mdl[$];
  cmd_t cmds[NCMD];
  cmd_t m;

  logic       stop_m = 1'b1;
  logic [7:0] cur_lo = 8'h00;
  logic [7:0] cur_hi = 8'h00;
  int ylo_run = 0, yhi_run = 0, k = 0;
  bit armed = 0;
  int start_tot = 0, ylo_tot = 0, yhi_tot = 0, gap_err = 0, ovl_err = 0;
  int s_start = 0, s_ylo = 0, s_yhi = 0, s_gap = 0, s_ovl = 0;
  logic [7:0] pre_eab = 0, pre_edb = 0, last_eab = 0, last_edb = 0;
  logic prev_ylo = 0, prev_yhi = 0;

  assign bus.mb_stop = stop_m;
  // Correct data only on the final strobe clock, so an early capture is visible.
  assign bus.mb_edb_out = bus.mb_ylo ? ((ylo_run == RD) ? cur_lo : ~cur_lo) :
                          bus.mb_yhi ? ((yhi_run == RD) ? cur_hi : ~cur_hi) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk_6MHz);
    #1;
  endtask

  function automatic exp_t mk_exp(input cmd_t c, input int acc);
    exp_t e;
    e.addr = c.addr;
    e.data = c.data;
    e.hold = c.hold;
    e.acc  = acc;
    if (c.stop_n < 0 || c.stop_n >= TO) begin
      e.result = 16'hFFFF;
      e.to     = 1'b1;
      e.rd     = 1'b0;
      e.lat    = WR + 3 + TO;
    end else begin
      e.result = c.rd ? {c.hi, c.lo} : 16'h0000;
      e.to     = 1'b0;
      e.rd     = c.rd;
      e.lat    = WR + 4 + c.stop_n + (c.rd ? 2 * RD + 1 : 0);
    end
    return e;
  endfunction

  task automatic snapshot();
    s_start = start_tot;
    s_ylo   = ylo_tot;
    s_yhi   = yhi_tot;
    s_gap   = gap_err;
    s_ovl   = ovl_err;
  endtask

  task automatic drive_cmds();
    int w;
    for (int i = 0; i < NCMD && !abort; i++) begin
      bus.cmd_addr  = cmds[i].addr;
      bus.cmd_data  = cmds[i].data;
      bus.cmd_read  = cmds[i].rd;
      bus.cmd_valid = 1'b1;
      w = 0;
      while (!bus.cmd_ready && w < WAIT_MAX && !abort) begin
        tick();
        w++;
      end
      if (!bus.cmd_ready) begin
        check("accept_wait", {31'd0, bus.cmd_ready}, 1);
        abort = 1;
        break;
      end
      if (i > 0) check("b2b_accept", cyc - hs_cyc, 1);
      mdl.push_back(cmds[i]);
      sb.push_back(mk_exp(cmds[i], cyc));
      tick();
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic consume_rsps();
    int   w;
    exp_t e;
    for (int i = 0; i < NCMD; i++) begin
      w = 0;
      while (!bus.rsp_valid && w < WAIT_MAX && !abort) begin
        tick();
        w++;
      end
      if (!bus.rsp_valid) begin
        check("rsp_wait", {31'd0, bus.rsp_valid}, 1);
        abort = 1;
        break;
      end
      check("sb_depth", sb.size(), 1);
      e = sb.pop_front();
      check("rsp_result", bus.rsp_result, e.result);
      check("rsp_timeout", bus.rsp_timeout, e.to);
      check("latency", cyc - e.acc, e.lat);
      check("start_pulses", start_tot - s_start, 1);
      check("eab_pre_start", pre_eab, e.addr);
      check("edb_pre_start", pre_edb, e.data);
      check("ylo_clocks", ylo_tot - s_ylo, e.rd ? RD : 0);
      check("yhi_clocks", yhi_tot - s_yhi, e.rd ? RD : 0);
      check("strobe_gap", gap_err - s_gap, 0);
      check("strobe_overlap", ovl_err - s_ovl, 0);
      check("busy_resp", busy, 1);
      for (int h = 0; h < e.hold; h++) begin
        tick();
        check("bp_valid", bus.rsp_valid, 1);
        check("bp_result", bus.rsp_result, e.result);
        check("bp_cmd_ready", bus.cmd_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      hs_cyc = cyc;
      tick();
      bus.rsp_ready = 1'b0;
      check("post_hs_valid", bus.rsp_valid, 0);
      check("post_hs_result", bus.rsp_result, e.result);
      check("post_hs_timeout", bus.rsp_timeout, e.to);
      check("idle_eab", bus.mb_eab, 0);
      snapshot();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_data  = 8'h00;
    bus.cmd_read  = 1'b0;
    bus.rsp_ready = 1'b0;

    cmds[0] = '{8'h15, 8'h3C, 1'b1, 20,     8'h34, 8'h12, 0};
    cmds[1] = '{8'h22, 8'h5A, 1'b0, 3,      8'hEE, 8'hDD, 0};
    cmds[2] = '{8'h33, 8'hA5, 1'b1, -1,     8'hAA, 8'hBB, 0};
    cmds[3] = '{8'h44, 8'h11, 1'b1, 4,      8'h78, 8'h56, 7};
    cmds[4] = '{8'h55, 8'h22, 1'b0, 0,      8'h00, 8'h00, 0};
    cmds[5] = '{8'h66, 8'h33, 1'b1, TO - 1, 8'hCD, 8'hAB, 0};
    cmds[6] = '{8'h77, 8'h44, 1'b1, 1,      8'h9F, 8'h80, 2};

    // Math Box model and bus monitor, evaluated on the falling edge.
    fork
      forever begin
        @(negedge clk_6MHz);
        cyc++;
        if (bus.mb_ylo && bus.mb_yhi) ovl_err++;
        if (bus.mb_yhi && !prev_yhi && prev_ylo) gap_err++;
        ylo_run = bus.mb_ylo ? ylo_run + 1 : 0;
        yhi_run = bus.mb_yhi ? yhi_run + 1 : 0;
        if (bus.mb_ylo) ylo_tot++;
        if (bus.mb_yhi) yhi_tot++;
        if (bus.mb_start) begin
          start_tot++;
          pre_eab = last_eab;
          pre_edb = last_edb;
          if (mdl.size() > 0) begin
            m      = mdl.pop_front();
            cur_lo = m.lo;
            cur_hi = m.hi;
            armed  = 1;
            k      = 0;
            stop_m = 1'b0;
          end
        end else if (armed) begin
          k++;
          if (m.stop_n >= 0 && k == m.stop_n + 2) begin
            stop_m = 1'b1;
            armed  = 0;
          end
        end
        prev_ylo = bus.mb_ylo;
        prev_yhi = bus.mb_yhi;
        last_eab = bus.mb_eab;
        last_edb = bus.mb_edb_in;
      end
    join_none

    repeat (3) tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_start", bus.mb_start, 0);
    check("rst_strobes", {bus.mb_ylo, bus.mb_yhi}, 0);
    check("rst_eab", bus.mb_eab, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of RUN must abort with no response.
    mdl.push_back('{8'h7E, 8'h81, 1'b1, -1, 8'h00, 8'h00, 0});
    check("pre_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_addr  = 8'h7E;
    bus.cmd_data  = 8'h81;
    bus.cmd_read  = 1'b1;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (WR + 4) tick();
    check("run_busy", busy, 1);
    check("run_eab", bus.mb_eab, 8'h7E);
    reset_n = 1'b0;
    tick();
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_start", bus.mb_start, 0);
    check("midrst_eab", bus.mb_eab, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    reset_n = 1'b1;
    repeat (4) tick();
    check("midrst_no_rsp", bus.rsp_valid, 0);
    check("midrst_idle", busy, 0);
    snapshot();

    fork
      drive_cmds();
      consume_rsps();
    join
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
